// File: rtl/eth_pcs_params.sv
// rtl/eth_pcs_params.sv - PCS block width, descrambler taps and assembler state type
package eth_pcs_params;

    import eth_pcs_pkg::*;

    localparam int W_BLK       = 2 * W_DATA;
    localparam int DESCR_TAP_A = 39;
    localparam int DESCR_TAP_B = 58;

    typedef enum logic {
        HALF_LO = 1'b0,
        HALF_HI = 1'b1
    } half_e;

endpackage

// File: rtl/eth_pcs_pkg.sv
// rtl/eth_pcs_pkg.sv - shared PCS datapath widths
package eth_pcs_pkg;

    localparam int W_DATA = 32;
    localparam int W_SYNC = 2;

endpackage

// File: rtl/eth_pcs_descrambler_core.sv
// rtl/eth_pcs_descrambler_core.sv - combinational 1+x^39+x^58 descramble of one word
module eth_pcs_descrambler_core
    import eth_pcs_pkg::*;
    import eth_pcs_params::*;
(
    input  logic [W_DATA-1:0]      i_word,
    input  logic [DESCR_TAP_B-1:0] i_hist,
    output logic [W_DATA-1:0]      o_word,
    output logic [DESCR_TAP_B-1:0] o_hist
);

    // History is oldest-first: i_hist[0] is in[n-58], i_hist[57] the most recent bit.
    // Appending the word above it gives one contiguous wire-ordered stream.
    logic [DESCR_TAP_B+W_DATA-1:0] stream;

    assign stream = {i_word, i_hist};

    always_comb begin
        o_word = '0;
        for (int i = 0; i < W_DATA; i++) begin
            o_word[i] = stream[DESCR_TAP_B + i]
                      ^ stream[DESCR_TAP_B - DESCR_TAP_A + i]
                      ^ stream[i];
        end
        o_hist = stream[DESCR_TAP_B+W_DATA-1 -: DESCR_TAP_B];
    end

endmodule

// File: rtl/eth_pcs_rx_descrambler.sv
// rtl/eth_pcs_rx_descrambler.sv - RX descrambler with 66b block assembly from 32-bit gearbox words
module eth_pcs_rx_descrambler
    import eth_pcs_pkg::*;
    import eth_pcs_params::*;
#(
    parameter int DESCR_BYPASS = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_grbx_hdr_valid,
    input  logic [W_SYNC-1:0] i_grbx_hdr,
    input  logic              i_grbx_data_valid,
    input  logic [W_DATA-1:0] i_grbx_data,
    input  logic              i_rx_lock,
    output logic              o_desc_valid,
    output logic [W_SYNC-1:0] o_desc_hdr,
    output logic [W_BLK-1:0]  o_desc_data,
    output logic              o_desc_err
);

    logic [DESCR_TAP_B-1:0] hist_q, hist_d;
    half_e                  half_q, half_d;
    logic                   hdr_pend_q, hdr_pend_d;
    logic [W_SYNC-1:0]      blk_hdr_q, blk_hdr_d;
    logic [W_DATA-1:0]      lo_q, lo_d;
    logic                   desc_valid_q, desc_valid_d;
    logic                   desc_err_q, desc_err_d;
    logic [W_SYNC-1:0]      desc_hdr_q, desc_hdr_d;
    logic [W_BLK-1:0]       desc_data_q, desc_data_d;

    logic [W_DATA-1:0]      core_word;
    logic [DESCR_TAP_B-1:0] core_hist;
    logic [W_DATA-1:0]      word;

    eth_pcs_descrambler_core u_core (
        .i_word (i_grbx_data),
        .i_hist (hist_q),
        .o_word (core_word),
        .o_hist (core_hist)
    );

    assign word = (DESCR_BYPASS != 0) ? i_grbx_data : core_word;

    always_comb begin
        hist_d       = hist_q;
        half_d       = half_q;
        hdr_pend_d   = hdr_pend_q;
        blk_hdr_d    = blk_hdr_q;
        lo_d         = lo_q;
        desc_valid_d = 1'b0;
        desc_err_d   = 1'b0;
        desc_hdr_d   = desc_hdr_q;
        desc_data_d  = desc_data_q;

        // The self-synchronous history tracks the wire, independent of lock and bypass.
        if (i_grbx_data_valid) begin
            hist_d = core_hist;
        end

        if (!i_rx_lock) begin
            half_d     = HALF_LO;
            hdr_pend_d = 1'b0;
            desc_err_d = (half_q == HALF_HI);
        end else if (i_grbx_hdr_valid && !i_grbx_data_valid) begin
            desc_err_d = (half_q == HALF_HI);
            half_d     = HALF_LO;
            hdr_pend_d = 1'b1;
            blk_hdr_d  = i_grbx_hdr;
        end else if (i_grbx_data_valid) begin
            if (i_grbx_hdr_valid || hdr_pend_q) begin
                // A header always restarts the block, abandoning any half-built one.
                desc_err_d = (half_q == HALF_HI);
                lo_d       = word;
                half_d     = HALF_HI;
                hdr_pend_d = 1'b0;
                if (i_grbx_hdr_valid) begin
                    blk_hdr_d = i_grbx_hdr;
                end
            end else if (half_q == HALF_HI) begin
                desc_data_d  = {word, lo_q};
                desc_hdr_d   = blk_hdr_q;
                desc_valid_d = 1'b1;
                half_d       = HALF_LO;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hist_q       <= '0;
            half_q       <= HALF_LO;
            hdr_pend_q   <= 1'b0;
            blk_hdr_q    <= '0;
            lo_q         <= '0;
            desc_valid_q <= 1'b0;
            desc_err_q   <= 1'b0;
            desc_hdr_q   <= '0;
            desc_data_q  <= '0;
        end else begin
            hist_q       <= hist_d;
            half_q       <= half_d;
            hdr_pend_q   <= hdr_pend_d;
            blk_hdr_q    <= blk_hdr_d;
            lo_q         <= lo_d;
            desc_valid_q <= desc_valid_d;
            desc_err_q   <= desc_err_d;
            desc_hdr_q   <= desc_hdr_d;
            desc_data_q  <= desc_data_d;
        end
    end

    assign o_desc_valid = desc_valid_q;
    assign o_desc_err   = desc_err_q;
    assign o_desc_hdr   = desc_hdr_q;
    assign o_desc_data  = desc_data_q;

endmodule

// File: tb/tb_eth_pcs_rx_descrambler.sv
// tb/tb_eth_pcs_rx_descrambler.sv - scoreboard bench for eth_pcs_rx_descrambler
module tb_eth_pcs_rx_descrambler;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_grbx_hdr_valid;
    logic [1:0]  i_grbx_hdr;
    logic        i_grbx_data_valid;
    logic [31:0] i_grbx_data;
    logic        i_rx_lock;

    logic        d_valid, d_err, b_valid, b_err;
    logic [1:0]  d_hdr, b_hdr;
    logic [63:0] d_data, b_data;

    always #5 clk = ~clk;

    eth_pcs_rx_descrambler #(.DESCR_BYPASS(0)) dut (
        .i_clk             (clk),
        .i_reset           (i_reset),
        .i_grbx_hdr_valid  (i_grbx_hdr_valid),
        .i_grbx_hdr        (i_grbx_hdr),
        .i_grbx_data_valid (i_grbx_data_valid),
        .i_grbx_data       (i_grbx_data),
        .i_rx_lock         (i_rx_lock),
        .o_desc_valid      (d_valid),
        .o_desc_hdr        (d_hdr),
        .o_desc_data       (d_data),
        .o_desc_err        (d_err)
    );

    eth_pcs_rx_descrambler #(.DESCR_BYPASS(1)) dut_byp (
        .i_clk             (clk),
        .i_reset           (i_reset),
        .i_grbx_hdr_valid  (i_grbx_hdr_valid),
        .i_grbx_hdr        (i_grbx_hdr),
        .i_grbx_data_valid (i_grbx_data_valid),
        .i_grbx_data       (i_grbx_data),
        .i_rx_lock         (i_rx_lock),
        .o_desc_valid      (b_valid),
        .o_desc_hdr        (b_hdr),
        .o_desc_data       (b_data),
        .o_desc_err        (b_err)
    );

    typedef struct {
        bit          is_err;
        bit          chk;
        logic [1:0]  hdr;
        logic [63:0] data;
        logic [63:0] raw;
    } ev_t;

    ev_t         sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [57:0] scr_st;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference scrambler: s[n] = d[n] ^ s[n-39] ^ s[n-58]; scr_st[0] is s[n-1].
    function automatic logic [31:0] scramble(input logic [31:0] p);
        logic [31:0] s;
        for (int i = 0; i < 32; i++) begin
            s[i]   = p[i] ^ scr_st[38] ^ scr_st[57];
            scr_st = {scr_st[56:0], s[i]};
        end
        return s;
    endfunction

    task automatic drive(input logic hv, input logic [1:0] h, input logic dv,
                         input logic [31:0] d, input logic lk);
        @(posedge clk);
        #1;
        i_grbx_hdr_valid  = hv;
        i_grbx_hdr        = h;
        i_grbx_data_valid = dv;
        i_grbx_data       = d;
        i_rx_lock         = lk;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 1'b0, $urandom, 1'b1);
    endtask

    task automatic push_blk(input bit chk, input logic [1:0] h, input logic [63:0] data,
                            input logic [63:0] raw);
        ev_t e;
        e.is_err = 1'b0;
        e.chk    = chk;
        e.hdr    = h;
        e.data   = data;
        e.raw    = raw;
        sb.push_back(e);
    endtask

    task automatic push_err();
        ev_t e;
        e.is_err = 1'b1;
        e.chk    = 1'b0;
        e.hdr    = 2'b00;
        e.data   = '0;
        e.raw    = '0;
        sb.push_back(e);
    endtask

    task automatic send_block(input logic [1:0] h, input bit chk);
        logic [31:0] plo, phi, slo, shi;
        plo = $urandom;
        phi = $urandom;
        slo = scramble(plo);
        shi = scramble(phi);
        drive(1'b1, h, 1'b1, slo, 1'b1);
        drive(1'b0, 2'b00, 1'b1, shi, 1'b1);
        push_blk(chk, h, {phi, plo}, {shi, slo});
    endtask

    always @(negedge clk) begin
        if (d_valid || d_err || b_valid || b_err) begin
            check("valid_err_exclusive", {63'd0, d_valid & d_err}, 64'd0);
            check("byp_strobes", {62'd0, b_valid, b_err}, {62'd0, d_valid, d_err});
            if (sb.size() == 0) begin
                check("unexpected_event", {62'd0, d_valid, d_err}, 64'd0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("event_is_err", {63'd0, d_err}, {63'd0, e.is_err});
                if (!e.is_err) begin
                    check("hdr", {62'd0, d_hdr}, {62'd0, e.hdr});
                    check("byp_hdr", {62'd0, b_hdr}, {62'd0, e.hdr});
                    check("byp_data", b_data, e.raw);
                    if (e.chk) check("data", d_data, e.data);
                end
            end
        end
    end

    initial begin
        logic [31:0] plo, phi, pb, sa, sb_w, sc;
        logic [63:0] last;

        i_reset           = 1'b1;
        i_grbx_hdr_valid  = 1'b0;
        i_grbx_hdr        = 2'b00;
        i_grbx_data_valid = 1'b0;
        i_grbx_data       = '0;
        i_rx_lock         = 1'b0;
        scr_st            = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {63'd0, d_valid}, 64'd0);
        check("rst_err", {63'd0, d_err}, 64'd0);
        check("rst_hdr", {62'd0, d_hdr}, 64'd0);
        check("rst_data", d_data, 64'd0);
        check("rst_byp_data", b_data, 64'd0);
        i_reset = 1'b0;

        // Known-answer block from a zeroed history.
        drive(1'b1, 2'b01, 1'b1, 32'h0000_0001, 1'b1);
        drive(1'b0, 2'b00, 1'b1, 32'h0000_0000, 1'b1);
        push_blk(1'b1, 2'b01, 64'h04000080_00000001, 64'h00000000_00000001);
        idle(3);
        check("kat_hold_data", d_data, 64'h04000080_00000001);
        check("kat_hold_byp", b_data, 64'h00000000_00000001);

        // Long run from a random scrambler seed; the first block cannot be trusted.
        scr_st = {$urandom, $urandom};
        for (int k = 0; k < 1000; k++) begin
            send_block(($urandom & 1) ? 2'b01 : 2'b10, k != 0);
        end
        idle(2);

        // One idle cycle between halves with garbage on the data bus.
        plo = $urandom;
        phi = $urandom;
        sa  = scramble(plo);
        drive(1'b1, 2'b10, 1'b1, sa, 1'b1);
        drive(1'b0, 2'b00, 1'b0, $urandom, 1'b1);
        sc  = scramble(phi);
        drive(1'b0, 2'b00, 1'b1, sc, 1'b1);
        push_blk(1'b1, 2'b10, {phi, plo}, {sc, sa});
        idle(3);
        check("gap_hold_data", d_data, {phi, plo});

        // Header on the second word: error, then that word opens a new block.
        sa   = scramble($urandom);
        drive(1'b1, 2'b01, 1'b1, sa, 1'b1);
        pb   = $urandom;
        sb_w = scramble(pb);
        drive(1'b1, 2'b10, 1'b1, sb_w, 1'b1);
        push_err();
        phi  = $urandom;
        sc   = scramble(phi);
        drive(1'b0, 2'b00, 1'b1, sc, 1'b1);
        push_blk(1'b1, 2'b10, {phi, pb}, {sc, sb_w});
        idle(2);

        // Headerless word at half=0 is dropped silently.
        drive(1'b0, 2'b00, 1'b1, scramble($urandom), 1'b1);
        idle(2);
        send_block(2'b01, 1'b1);

        // Header arriving without data; the next data word becomes the low half.
        drive(1'b1, 2'b10, 1'b0, $urandom, 1'b1);
        plo = $urandom;
        phi = $urandom;
        sa  = scramble(plo);
        drive(1'b0, 2'b00, 1'b1, sa, 1'b1);
        sc  = scramble(phi);
        drive(1'b0, 2'b00, 1'b1, sc, 1'b1);
        push_blk(1'b1, 2'b10, {phi, plo}, {sc, sa});
        idle(2);

        // Lock loss mid-block: one error pulse, then nothing until a new header.
        drive(1'b1, 2'b01, 1'b1, scramble($urandom), 1'b1);
        drive(1'b0, 2'b00, 1'b0, $urandom, 1'b0);
        push_err();
        drive(1'b0, 2'b00, 1'b1, scramble($urandom), 1'b0);
        drive(1'b0, 2'b00, 1'b1, scramble($urandom), 1'b1);
        idle(2);
        send_block(2'b10, 1'b1);
        idle(2);
        last = d_data;

        // Reset mid-block: no error, outputs and history cleared.
        drive(1'b1, 2'b01, 1'b1, scramble($urandom), 1'b1);
        @(posedge clk);
        #1;
        i_reset           = 1'b1;
        i_grbx_hdr_valid  = 1'b0;
        i_grbx_data_valid = 1'b0;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        @(negedge clk);
        check("midrst_data", d_data, 64'd0);
        check("midrst_hdr", {62'd0, d_hdr}, 64'd0);
        check("midrst_data_changed", {63'd0, d_data === last}, {63'd0, last === 64'd0});
        scr_st = '0;
        drive(1'b0, 2'b00, 1'b1, scramble($urandom), 1'b1);
        idle(2);
        send_block(2'b01, 1'b1);
        idle(4);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
